// File: rtl/alu_sched_pkg.sv
// Shared constants, state encoding and command record for the ALU/memory scheduler.
// The ALU op set fixes the 3-bit data width; the memory depth follows ADDR_W.
package alu_sched_pkg;
  localparam int DATA_W  = 3;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int NUM_REQ = 2;
  localparam int OP_W    = 3;
  localparam int OPND_W  = 2;
  localparam int MEMOP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;

  localparam logic [MEMOP_W-1:0] MEM_NONE  = 2'b00;
  localparam logic [MEMOP_W-1:0] MEM_STORE = 2'b01;
  localparam logic [MEMOP_W-1:0] MEM_LOAD  = 2'b10;
  localparam logic [MEMOP_W-1:0] MEM_ILL   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MEM, ST_RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [OPND_W-1:0]  a;
    logic [OPND_W-1:0]  b;
    logic [ADDR_W-1:0]  addr;
    logic [MEMOP_W-1:0] memop;
    logic               id;
  } cmd_t;
endpackage

// File: rtl/alu_mem_scheduler_if.sv
// Command/response bus between the two requesters and the scheduler.
// Per-requester fields are flat-packed, requester 0 in the low slice.
interface alu_mem_scheduler_if;
  import alu_sched_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*OP_W-1:0]    req_op;
  logic [NUM_REQ*OPND_W-1:0]  req_a;
  logic [NUM_REQ*OPND_W-1:0]  req_b;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*MEMOP_W-1:0] req_memop;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [DATA_W-1:0]          rsp_y;
  logic [DATA_W-1:0]          rsp_mem;
  logic                       rsp_err;
  logic                       busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_addr, req_memop, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_mem, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_addr, req_memop, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_mem, rsp_err, busy
  );
endinterface

// File: rtl/alu_mem_datapath.sv
// Combinational 3-bit ALU plus 16x3 scratch memory with per-word written flags.
// Unwritten words read as zero, so only the flags need a reset.
module alu_mem_datapath
  import alu_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     i_op,
  input  logic [OPND_W-1:0]   i_a,
  input  logic [OPND_W-1:0]   i_b,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_wr_en,
  input  logic [DATA_W-1:0]   i_wr_data,
  output logic [DATA_W-1:0]   o_y,
  output logic                o_op_err,
  output logic [DATA_W-1:0]   o_rd_data
);
  logic [DATA_W-1:0] w_a, w_b;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;

  assign w_a = {{(DATA_W-OPND_W){1'b0}}, i_a};
  assign w_b = {{(DATA_W-OPND_W){1'b0}}, i_b};

  always_comb begin
    o_y      = '0;
    o_op_err = 1'b0;
    case (i_op)
      OP_ADD:  o_y = w_a + w_b;
      OP_SUB:  o_y = w_a - w_b;
      OP_AND:  o_y = w_a & w_b;
      OP_OR:   o_y = w_a | w_b;
      OP_NOT:  o_y = ~w_a;
      default: o_op_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_written <= '0;
    else if (i_wr_en) r_written[i_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_addr] <= i_wr_data;
  end

  assign o_rd_data = r_written[i_addr] ? r_mem[i_addr] : '0;
endmodule

// File: rtl/alu_mem_scheduler.sv
// Round-robin scheduler sharing one ALU + scratch memory between two requesters.
// One command in flight: IDLE -> EXEC -> MEM -> RESP -> IDLE.
module alu_mem_scheduler
  import alu_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_mem_scheduler_if.slave bus
);
  logic [NUM_REQ-1:0][OP_W-1:0]    w_op;
  logic [NUM_REQ-1:0][OPND_W-1:0]  w_a, w_b;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  w_addr;
  logic [NUM_REQ-1:0][MEMOP_W-1:0] w_memop;

  state_t            r_state, w_state_nxt;
  cmd_t              r_cmd;
  logic              r_last;
  logic              w_grant, w_acc, w_rsp_hs, w_wr_en, w_op_err;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0] w_y, w_rd, r_y, r_mem_q;
  logic              r_op_err, r_err, r_rsp_valid;

  assign w_op    = bus.req_op;
  assign w_a     = bus.req_a;
  assign w_b     = bus.req_b;
  assign w_addr  = bus.req_addr;
  assign w_memop = bus.req_memop;

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    w_grant = ~r_last;
    if (bus.req_valid == 2'b01)      w_grant = 1'b0;
    else if (bus.req_valid == 2'b10) w_grant = 1'b1;
  end

  assign w_acc    = (r_state == ST_IDLE) && bus.req_valid[w_grant];
  assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready;
  assign w_wr_en  = (r_state == ST_MEM) && (r_cmd.memop == MEM_STORE) && !r_op_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      ST_IDLE: begin
        w_ready[w_grant] = bus.req_valid[w_grant];
        if (bus.req_valid[w_grant]) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_MEM;
      ST_MEM:  w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_last      <= 1'b1;
      r_y         <= '0;
      r_op_err    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_q     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_cmd.op    <= w_op[w_grant];
        r_cmd.a     <= w_a[w_grant];
        r_cmd.b     <= w_b[w_grant];
        r_cmd.addr  <= w_addr[w_grant];
        r_cmd.memop <= w_memop[w_grant];
        r_cmd.id    <= w_grant;
      end
      if (r_state == ST_EXEC) begin
        r_y      <= w_y;
        r_op_err <= w_op_err;
      end
      if (r_state == ST_MEM) begin
        r_err       <= r_op_err | (r_cmd.memop == MEM_ILL);
        r_mem_q     <= (r_cmd.memop == MEM_LOAD) ? w_rd : '0;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_last      <= r_cmd.id;
      end
    end
  end

  alu_mem_datapath u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_op      (r_cmd.op),
    .i_a       (r_cmd.a),
    .i_b       (r_cmd.b),
    .i_addr    (r_cmd.addr),
    .i_wr_en   (w_wr_en),
    .i_wr_data (r_y),
    .o_y       (w_y),
    .o_op_err  (w_op_err),
    .o_rd_data (w_rd)
  );

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_cmd.id;
  assign bus.rsp_y     = r_y;
  assign bus.rsp_mem   = r_mem_q;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = (r_state != ST_IDLE);
endmodule
